weighted_round_robin_dispatcher: RTL and testbench
==================================================

Name: weighted_round_robin_dispatcher

Overview:
- Single-input, N-output stream distributor: the dual of the weighted round-robin arbiter.
- Takes one valid/ready stream and steers each accepted beat to exactly one of N output ports.
- Each port receives a share of beats set by a per-port weight, in weighted round-robin order.
- Each output port has a one-deep registered slot, so no output depends combinationally on i_data.
- Sits between a shared producer and N parallel consumers, e.g. load-spreading to replicated engines.

Parameters:
- PORT_WIDTH, 2, number of output ports N (>=1).
- DATA_WIDTH, 8, payload width.
- WEIGHT_WIDTH, 2, width of each weight/credit counter.
- WEIGHT, '1, bit [PORT_WIDTH-1:0][WEIGHT_WIDTH-1:0]. Beats per round for each port. WEIGHT[k]=0 disables port k.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  upstream beat valid
- o_ready  output  1  upstream beat accepted this cycle when i_valid&o_ready
- i_data  input  DATA_WIDTH  upstream payload
- o_valid  output  PORT_WIDTH  per-port slot valid
- i_ready  input  PORT_WIDTH  per-port consumer ready
- o_data  output  PORT_WIDTH x DATA_WIDTH  per-port slot payload
- o_select  output  IDX (=max(1,$clog2(N)))  index of the port receiving the current beat; valid only when i_valid&o_ready

Behaviour:
- Reset is i_rst_n, asynchronous, active-low; clock is i_clk.
- Reset values:
  - o_valid='0, o_data='0.
  - credit[k]=WEIGHT[k].
  - pointer=0.
- Per-port terms:
  - accept[k] = WEIGHT[k]!=0 && (!o_valid[k] || i_ready[k]).
  - elig[k] = accept[k] && credit[k]!=0.
- Selection (combinational):
  - If elig != 0: pick the first set bit of elig in cyclic order starting at pointer, pointer itself included.
  - Else if accept != 0: reload case. Pick the first set bit of accept in cyclic order from pointer.
  - Else: no pick.
- o_ready = (accept != 0). o_ready depends combinationally on i_ready; it does not depend on i_valid. o_select = picked index.
- Transfer (i_valid&o_ready, picked port p):
  - Normal case: credit[p] <= credit[p]-1.
  - Reload case: every credit[k] <= WEIGHT[k], except credit[p] <= WEIGHT[p]-1.
  - Normal case, but after the decrement every enabled port's credit is 0: all credits <= WEIGHT, so the next round starts fresh.
  - Pointer: if the updated credit[p] > 0, pointer <= p (burst continues); else pointer <= (p+1) mod N.
  - Slot p: o_valid[p] <= 1, o_data[p] <= i_data. This holds even if i_ready[p]=1 in the same cycle (drain and refill).
- Slot drain, for ports with no transfer this cycle: if o_valid[k]&&i_ready[k] then o_valid[k] <= 0. o_data holds its value.
- No transfer: credits and pointer hold.
- Latency: a beat accepted in cycle t is visible on o_valid/o_data at t+1. Throughput is 1 beat/cycle while any port can accept.
- Ordering: no reordering within a port. No ordering guarantee across ports.
- Consumer-side handshake: o_data[k] is stable while o_valid[k]&&!i_ready[k].
- Blocked ports: a port whose slot is full and not draining is skipped. Its credit is kept until the next reload (work-conserving).
- All WEIGHT=0: o_ready is stuck at 0. This is a legal but useless configuration.
- N=1: the block degenerates to a one-deep pipeline register. Credits still count but have no effect on steering.
- Credit arithmetic is unsigned WEIGHT_WIDTH. A decrement is never applied to 0.
- Reset asserted mid-stream: slots are dropped, credits reload, pointer returns to 0. Any beat in flight is lost.

Test Plan:
1. N=3, WEIGHT={3,2,1} (port0=1, port1=2, port2=3), i_valid=1, i_ready='1 -> o_select sequence 0,1,1,2,2,2,0,1,1,2,... and o_ready=1 every cycle.
2. Same configuration, i_ready[1]=0 permanently -> sequence 0,1,2,2,2. Then port1's slot is full, so the next pick is a reload case: 0,2,2,2,0,2,2,2,... o_data[1] holds the first beat sent to port 1.
3. All i_ready=0, continuous valid -> exactly three beats accepted (one per slot), then o_ready=0. Raise i_ready[2] for one cycle -> exactly one more beat accepted, and it goes to port 2.
4. Drain-and-refill: port0 slot full, i_ready[0]=1, port0 picked -> o_valid[0] stays 1 and o_data[0] updates next cycle, with no bubble.
5. WEIGHT={1,0,1} -> port1 is never selected (o_valid[1] stays 0). Sequence alternates 0,2,0,2.
6. Assert i_rst_n=0 asynchronously mid-burst -> o_valid=0 immediately. After release, the first pick is port 0 with full credits.

Source files
------------

// File: rtl/weighted_round_robin_dispatcher.sv
// Single-input, N-output weighted round-robin stream dispatcher.
// Each accepted beat is steered to one port's one-deep registered output slot.
module weighted_round_robin_dispatcher #(
    parameter int unsigned PORT_WIDTH   = 2,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned WEIGHT_WIDTH = 2,
    parameter bit [PORT_WIDTH-1:0][WEIGHT_WIDTH-1:0] WEIGHT = '1,
    localparam int unsigned IDX = (PORT_WIDTH > 1) ? $clog2(PORT_WIDTH) : 1
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_valid,
    output logic                                  o_ready,
    input  logic [DATA_WIDTH-1:0]                 i_data,
    output logic [PORT_WIDTH-1:0]                 o_valid,
    input  logic [PORT_WIDTH-1:0]                 i_ready,
    output logic [PORT_WIDTH-1:0][DATA_WIDTH-1:0] o_data,
    output logic [IDX-1:0]                        o_select
);

    logic [PORT_WIDTH-1:0][WEIGHT_WIDTH-1:0] r_credit;
    logic [PORT_WIDTH-1:0][WEIGHT_WIDTH-1:0] w_credit_nxt;
    logic [IDX-1:0]                          r_ptr;
    logic [IDX-1:0]                          w_ptr_nxt;
    logic [PORT_WIDTH-1:0]                   r_valid;
    logic [PORT_WIDTH-1:0][DATA_WIDTH-1:0]   r_data;

    logic [PORT_WIDTH-1:0]                   w_enabled;
    logic [PORT_WIDTH-1:0]                   w_accept;
    logic [PORT_WIDTH-1:0]                   w_elig;
    logic [PORT_WIDTH-1:0]                   w_cand;
    logic [PORT_WIDTH-1:0]                   w_load;
    logic [IDX-1:0]                          w_pick;
    logic                                    w_found;
    logic                                    w_reload;
    logic                                    w_xfer;
    logic [WEIGHT_WIDTH-1:0]                 w_dec;
    logic                                    w_all_zero;

    function automatic logic [IDX-1:0] f_wrap(input logic [IDX-1:0] base,
                                              input int unsigned    off);
        int unsigned v;
        v = 32'(base) + off;
        if (v >= PORT_WIDTH) begin
            v = v - PORT_WIDTH;
        end
        return v[IDX-1:0];
    endfunction

    always_comb begin
        w_enabled = '0;
        w_accept  = '0;
        w_elig    = '0;
        for (int unsigned k = 0; k < PORT_WIDTH; k++) begin
            w_enabled[k] = (WEIGHT[k] != '0);
            w_accept[k]  = w_enabled[k] && (!r_valid[k] || i_ready[k]);
            w_elig[k]    = w_accept[k] && (r_credit[k] != '0);
        end
    end

    // Ports with credit win; once none has credit, any accepting port triggers a reload.
    assign w_reload = (w_elig == '0);
    assign w_cand   = w_reload ? w_accept : w_elig;

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int unsigned i = 0; i < PORT_WIDTH; i++) begin
            if (!w_found && w_cand[f_wrap(r_ptr, i)]) begin
                w_found = 1'b1;
                w_pick  = f_wrap(r_ptr, i);
            end
        end
    end

    assign o_ready  = (w_accept != '0);
    assign o_select = w_pick;
    assign w_xfer   = i_valid && o_ready;
    assign w_load   = w_xfer ? (PORT_WIDTH'(1) << w_pick) : '0;

    // The pointer follows the decremented credit, not the refreshed one,
    // so a round that ends on port p resumes at p+1.
    always_comb begin
        w_credit_nxt = r_credit;
        w_ptr_nxt    = r_ptr;
        w_dec        = '0;
        w_all_zero   = 1'b1;
        if (w_xfer) begin
            if (w_reload) begin
                w_credit_nxt = WEIGHT;
                w_dec        = WEIGHT[w_pick] - WEIGHT_WIDTH'(1);
            end else begin
                w_dec        = r_credit[w_pick] - WEIGHT_WIDTH'(1);
            end
            w_credit_nxt[w_pick] = w_dec;
            if (!w_reload) begin
                for (int unsigned k = 0; k < PORT_WIDTH; k++) begin
                    if (w_enabled[k] && (w_credit_nxt[k] != '0)) begin
                        w_all_zero = 1'b0;
                    end
                end
                if (w_all_zero) begin
                    w_credit_nxt = WEIGHT;
                end
            end
            w_ptr_nxt = (w_dec != '0) ? w_pick : f_wrap(w_pick, 1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_credit <= WEIGHT;
            r_ptr    <= '0;
            r_valid  <= '0;
            r_data   <= '0;
        end else begin
            r_credit <= w_credit_nxt;
            r_ptr    <= w_ptr_nxt;
            for (int unsigned k = 0; k < PORT_WIDTH; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= 1'b1;
                    r_data[k]  <= i_data;
                end else if (r_valid[k] && i_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: tb/tb_weighted_round_robin_dispatcher.sv
// Bench for weighted_round_robin_dispatcher: two 3-port instances with
// weights {1,2,3} and {1,0,1}, checked every cycle against a behavioural model.
module tb_weighted_round_robin_dispatcher;

    localparam int W [2][3] = '{'{1, 2, 3}, '{1, 0, 1}};

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;

    logic             a_valid = 1'b0, b_valid = 1'b0;
    logic [2:0]       a_ready = '0,   b_ready = '0;
    logic [7:0]       a_data  = '0,   b_data  = '0;
    logic             a_oready, b_oready;
    logic [2:0]       a_ovalid, b_ovalid;
    logic [1:0]       a_osel, b_osel;
    logic [2:0][7:0]  a_odata, b_odata;

    int               n_cmp = 0;
    int               n_err = 0;

    int               m_cr  [2][3];
    int               m_ptr [2];
    bit               m_sv  [2][3];
    int               m_sd  [2][3];
    int               selq_a[$];
    int               selq_b[$];

    int               exp1 [10] = '{0, 1, 1, 2, 2, 2, 0, 1, 1, 2};
    int               exp2 [13] = '{0, 1, 2, 2, 2, 0, 2, 2, 2, 0, 2, 2, 2};

    always #5 clk = ~clk;

    weighted_round_robin_dispatcher #(
        .PORT_WIDTH  (3),
        .DATA_WIDTH  (8),
        .WEIGHT_WIDTH(2),
        .WEIGHT      (6'b11_10_01)
    ) dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (a_valid),
        .o_ready (a_oready),
        .i_data  (a_data),
        .o_valid (a_ovalid),
        .i_ready (a_ready),
        .o_data  (a_odata),
        .o_select(a_osel)
    );

    weighted_round_robin_dispatcher #(
        .PORT_WIDTH  (3),
        .DATA_WIDTH  (8),
        .WEIGHT_WIDTH(2),
        .WEIGHT      (6'b01_00_01)
    ) dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (b_valid),
        .o_ready (b_oready),
        .i_data  (b_data),
        .o_valid (b_ovalid),
        .i_ready (b_ready),
        .o_data  (b_odata),
        .o_select(b_osel)
    );

    task automatic cmp(input int u, input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s [unit %0d] @%0t: got %0d, expected %0d", name, u, $time, act, exp);
        end
    endtask

    task automatic model_reset(input int u);
        m_ptr[u] = 0;
        for (int k = 0; k < 3; k++) begin
            m_cr[u][k] = W[u][k];
            m_sv[u][k] = 1'b0;
            m_sd[u][k] = 0;
        end
    endtask

    task automatic check_unit(input int u, input logic v, input logic [2:0] rdy,
                              input logic [7:0] d, input logic oready,
                              input logic [2:0] ovalid, input logic [1:0] osel,
                              input logic [2:0][7:0] odata);
        bit acc [3];
        bit el  [3];
        bit any_acc, any_el, allz, xfer;
        int pick, post, k;
        any_acc = 0;
        any_el  = 0;
        pick    = -1;
        post    = 0;
        for (int j = 0; j < 3; j++) begin
            acc[j]  = (W[u][j] != 0) && (!m_sv[u][j] || rdy[j]);
            el[j]   = acc[j] && (m_cr[u][j] > 0);
            any_acc = any_acc | acc[j];
            any_el  = any_el | el[j];
        end
        for (int i = 0; i < 3; i++) begin
            k = (m_ptr[u] + i) % 3;
            if (pick < 0 && (any_el ? el[k] : acc[k])) pick = k;
        end
        cmp(u, "o_ready", int'(oready), int'(any_acc));
        for (int j = 0; j < 3; j++) begin
            cmp(u, $sformatf("o_valid[%0d]", j), int'(ovalid[j]), int'(m_sv[u][j]));
            cmp(u, $sformatf("o_data[%0d]", j), int'(odata[j]), m_sd[u][j]);
        end
        xfer = v && any_acc;
        if (xfer) begin
            cmp(u, "o_select", int'(osel), pick);
            if (u == 0) selq_a.push_back(int'(osel));
            else        selq_b.push_back(int'(osel));
            if (any_el) begin
                m_cr[u][pick] = m_cr[u][pick] - 1;
                post = m_cr[u][pick];
                allz = 1;
                for (int j = 0; j < 3; j++)
                    if (W[u][j] != 0 && m_cr[u][j] != 0) allz = 0;
                if (allz)
                    for (int j = 0; j < 3; j++) m_cr[u][j] = W[u][j];
            end else begin
                for (int j = 0; j < 3; j++) m_cr[u][j] = W[u][j];
                m_cr[u][pick] = W[u][pick] - 1;
                post = m_cr[u][pick];
            end
            m_ptr[u] = (post > 0) ? pick : (pick + 1) % 3;
        end
        for (int j = 0; j < 3; j++) begin
            if (xfer && j == pick) begin
                m_sv[u][j] = 1'b1;
                m_sd[u][j] = int'(d);
            end else if (m_sv[u][j] && rdy[j]) begin
                m_sv[u][j] = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset(0);
            model_reset(1);
            cmp(0, "reset o_valid", int'(a_ovalid), 0);
            cmp(0, "reset o_data", int'(a_odata), 0);
            cmp(1, "reset o_valid", int'(b_ovalid), 0);
        end else begin
            check_unit(0, a_valid, a_ready, a_data, a_oready, a_ovalid, a_osel, a_odata);
            check_unit(1, b_valid, b_ready, b_data, b_oready, b_ovalid, b_osel, b_odata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        b_data = b_data + 8'd1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        selq_a.delete();
        selq_b.delete();
    endtask

    function automatic int qa(input int i);
        return (i < selq_a.size()) ? selq_a[i] : -1;
    endfunction

    function automatic int qb(input int i);
        return (i < selq_b.size()) ? selq_b[i] : -1;
    endfunction

    initial begin
        b_valid = 1'b1;
        b_ready = 3'b111;
        tick();
        do_reset();

        // Test 1 on A, test 5 on B concurrently
        a_valid = 1'b1;
        a_ready = 3'b111;
        for (int i = 0; i < 10; i++) begin
            a_data = 8'h00 + 8'(i);
            tick();
        end
        cmp(0, "t1 count", selq_a.size(), 10);
        for (int i = 0; i < 10; i++) cmp(0, "t1 sel seq", qa(i), exp1[i]);
        for (int i = 0; i < 4; i++) cmp(1, "t5 sel seq", qb(i), (i % 2 == 0) ? 0 : 2);
        cmp(1, "t5 port1 idle", int'(b_ovalid[1]), 0);

        // Test 2: port 1 never drains
        do_reset();
        a_ready = 3'b101;
        for (int i = 0; i < 13; i++) begin
            a_data = 8'h10 + 8'(i);
            tick();
        end
        cmp(0, "t2 count", selq_a.size(), 13);
        for (int i = 0; i < 13; i++) cmp(0, "t2 sel seq", qa(i), exp2[i]);
        cmp(0, "t2 slot1 valid", int'(a_ovalid[1]), 1);
        cmp(0, "t2 slot1 data", int'(a_odata[1]), 8'h11);

        // Test 3: all consumers stalled
        do_reset();
        a_ready = 3'b000;
        for (int i = 0; i < 5; i++) begin
            a_data = 8'h30 + 8'(i);
            tick();
        end
        cmp(0, "t3 count", selq_a.size(), 3);
        for (int i = 0; i < 3; i++) cmp(0, "t3 sel seq", qa(i), i);
        cmp(0, "t3 stalled ready", int'(a_oready), 0);
        a_ready = 3'b100;
        a_data  = 8'h40;
        tick();
        a_ready = 3'b000;
        a_data  = 8'h41;
        tick();
        tick();
        cmp(0, "t3 extra count", selq_a.size(), 4);
        cmp(0, "t3 extra sel", qa(3), 2);
        cmp(0, "t3 slot2 data", int'(a_odata[2]), 8'h40);

        // Test 4: drain and refill on port 0
        a_ready = 3'b001;
        a_data  = 8'h50;
        tick();
        cmp(0, "t4 valid0 a", int'(a_ovalid[0]), 1);
        cmp(0, "t4 data0 a", int'(a_odata[0]), 8'h50);
        a_data = 8'h51;
        tick();
        cmp(0, "t4 valid0 b", int'(a_ovalid[0]), 1);
        cmp(0, "t4 data0 b", int'(a_odata[0]), 8'h51);

        // Test 6: asynchronous reset mid-burst
        do_reset();
        a_ready = 3'b111;
        for (int i = 0; i < 4; i++) begin
            a_data = 8'h60 + 8'(i);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        cmp(0, "t6 async valid", int'(a_ovalid), 0);
        cmp(0, "t6 async data", int'(a_odata), 0);
        cmp(1, "t6 async valid", int'(b_ovalid), 0);
        tick();
        tick();
        rst_n = 1'b1;
        selq_a.delete();
        selq_b.delete();
        for (int i = 0; i < 3; i++) begin
            a_data = 8'h70 + 8'(i);
            tick();
        end
        cmp(0, "t6 sel0", qa(0), 0);
        cmp(0, "t6 sel1", qa(1), 1);
        cmp(0, "t6 sel2", qa(2), 1);
        cmp(1, "t6 b sel0", qb(0), 0);

        a_valid = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
